// File: rtl/rcc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rcc_pkg
//  Brief    : Shared types and sizing helpers for the bus clock-enable block.
//  Revision : 1.0  initial release
// ============================================================================
package rcc_pkg;

    // Per-channel idle state; RUN is the reset state.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_GATED = 2'd2
    } idle_state_e;

    // Prescaler counter width: must reach 2^(2^div_w-1)-1.
    function automatic int cnt_width(input int div_w);
        return (1 << div_w) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rcc_bus_clk_en_chan.sv
`default_nettype none
// ============================================================================
//  Module   : rcc_bus_clk_en_chan
//  Brief    : One bus channel: 2^n prescaler with boundary-aligned ratio
//             updates plus a RUN/HOLD/GATED idle FSM driving the ICG enable.
//  Revision : 1.0  initial release
// ============================================================================
module rcc_bus_clk_en_chan
    import rcc_pkg::*;
#(
    parameter int DIV_W  = 3,
    parameter int HOLD_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIV_W-1:0]  i_div_sel,
    input  logic              i_div_upd,
    input  logic              i_sleep_req,
    input  logic              i_busy,
    input  logic [HOLD_W-1:0] i_hold_cycles,
    output logic              o_clk_en,
    output logic              o_tick,
    output logic [DIV_W-1:0]  o_div_cur,
    output logic              o_gated_sts
);

    localparam int c_cnt_w = cnt_width(DIV_W);
    localparam logic [c_cnt_w-1:0] c_cnt_ones = '1;

    idle_state_e         r_state;
    idle_state_e         w_state_nxt;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_cnt_w-1:0]  w_term_val;
    logic [DIV_W-1:0]    r_div_cur;
    logic [DIV_W-1:0]    r_div_pend;
    logic                r_pend_v;
    logic                r_tick;
    logic                r_clk_en;
    logic                r_gated;
    logic                w_sleep_ok;
    logic                w_adv;
    logic                w_term;
    logic                w_clk_en_nxt;
    logic                w_gated_nxt;

    assign w_sleep_ok = i_sleep_req & ~i_busy;
    assign w_adv      = (r_state != ST_GATED);
    // Low div_cur bits set: the count value that closes one 2^div_cur period.
    assign w_term_val = ~(c_cnt_ones << r_div_cur);
    assign w_term     = w_adv && (r_cnt == w_term_val);

    // ------------------------------------------------------------------
    // Prescaler and ratio update
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_tick     <= 1'b0;
            r_div_cur  <= '0;
            r_div_pend <= '0;
            r_pend_v   <= 1'b0;
        end else begin
            if (w_adv) begin
                r_cnt <= w_term ? '0 : r_cnt + c_cnt_w'(1);
            end
            r_tick <= w_term;
            // Only a value already pending applies on this boundary; a
            // coincident update waits for the next one.
            if (w_term && r_pend_v) begin
                r_div_cur <= r_div_pend;
            end
            if (i_div_upd) begin
                r_div_pend <= i_div_sel;
                r_pend_v   <= 1'b1;
            end else if (w_term) begin
                r_pend_v   <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Idle FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Idle FSM: next state. Losing sleep eligibility always wins.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_sleep_ok) begin
                    w_state_nxt = (i_hold_cycles == '0) ? ST_GATED : ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!w_sleep_ok) begin
                    w_state_nxt = ST_RUN;
                end else if (r_hold_cnt >= i_hold_cycles) begin
                    w_state_nxt = ST_GATED;
                end
            end
            ST_GATED: begin
                if (!w_sleep_ok) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // Idle FSM: outputs, decoded from the next state and registered.
    always_comb begin
        w_clk_en_nxt = (w_state_nxt != ST_GATED);
        w_gated_nxt  = (w_state_nxt == ST_GATED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_en <= 1'b1;
            r_gated  <= 1'b0;
        end else begin
            r_clk_en <= w_clk_en_nxt;
            r_gated  <= w_gated_nxt;
        end
    end

    // Hold-off counter: counts eligible cycles spent in HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt <= '0;
        end else if ((r_state == ST_RUN) && (w_state_nxt == ST_HOLD)) begin
            r_hold_cnt <= HOLD_W'(1);
        end else if ((r_state == ST_HOLD) && (w_state_nxt == ST_HOLD)) begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
        end else begin
            r_hold_cnt <= '0;
        end
    end

    assign o_clk_en    = r_clk_en;
    assign o_tick      = r_tick;
    assign o_div_cur   = r_div_cur;
    assign o_gated_sts = r_gated;

endmodule
`default_nettype wire

// File: rtl/rcc_bus_clk_en_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rcc_bus_clk_en_ctrl
//  Brief    : Multi-channel bus clock-enable / prescaler controller in the
//             sys_clk domain; one rcc_bus_clk_en_chan per channel.
//  Revision : 1.0  initial release
// ============================================================================
module rcc_bus_clk_en_ctrl
    import rcc_pkg::*;
#(
    parameter int CH_NUM = 4,
    parameter int DIV_W  = 3,
    parameter int HOLD_W = 4
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic [CH_NUM*DIV_W-1:0] div_sel,
    input  logic [CH_NUM-1:0]       div_upd,
    input  logic [CH_NUM-1:0]       sleep_req,
    input  logic [CH_NUM-1:0]       busy,
    input  logic [HOLD_W-1:0]       hold_cycles,
    output logic [CH_NUM-1:0]       clk_en,
    output logic [CH_NUM-1:0]       tick,
    output logic [CH_NUM*DIV_W-1:0] div_cur,
    output logic [CH_NUM-1:0]       gated_sts
);

    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_chan
        rcc_bus_clk_en_chan #(
            .DIV_W  (DIV_W),
            .HOLD_W (HOLD_W)
        ) u_chan (
            .clk           (sys_clk),
            .rst_n         (sys_rst_n),
            .i_div_sel     (div_sel[gi*DIV_W +: DIV_W]),
            .i_div_upd     (div_upd[gi]),
            .i_sleep_req   (sleep_req[gi]),
            .i_busy        (busy[gi]),
            .i_hold_cycles (hold_cycles),
            .o_clk_en      (clk_en[gi]),
            .o_tick        (tick[gi]),
            .o_div_cur     (div_cur[gi*DIV_W +: DIV_W]),
            .o_gated_sts   (gated_sts[gi])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_rcc_bus_clk_en_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rcc_bus_clk_en_ctrl
//  Brief    : Directed and random stimulus against a cycle-level reference
//             model of the per-channel prescaler and idle gating rules.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rcc_bus_clk_en_ctrl;

    localparam int CH_NUM = 4;
    localparam int DIV_W  = 3;
    localparam int HOLD_W = 4;

    logic                    sys_clk = 1'b0;
    logic                    sys_rst_n;
    logic [CH_NUM*DIV_W-1:0] div_sel;
    logic [CH_NUM-1:0]       div_upd;
    logic [CH_NUM-1:0]       sleep_req;
    logic [CH_NUM-1:0]       busy;
    logic [HOLD_W-1:0]       hold_cycles;
    logic [CH_NUM-1:0]       clk_en;
    logic [CH_NUM-1:0]       tick;
    logic [CH_NUM*DIV_W-1:0] div_cur;
    logic [CH_NUM-1:0]       gated_sts;

    rcc_bus_clk_en_ctrl #(
        .CH_NUM (CH_NUM),
        .DIV_W  (DIV_W),
        .HOLD_W (HOLD_W)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .div_sel     (div_sel),
        .div_upd     (div_upd),
        .sleep_req   (sleep_req),
        .busy        (busy),
        .hold_cycles (hold_cycles),
        .clk_en      (clk_en),
        .tick        (tick),
        .div_cur     (div_cur),
        .gated_sts   (gated_sts)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;

    // Reference model: cycles left in the current period, pending ratio,
    // and count of consecutive sleep-eligible cycles.
    int m_left [CH_NUM];
    int m_cur  [CH_NUM];
    int m_pend [CH_NUM];
    int m_elig [CH_NUM];
    bit m_pv   [CH_NUM];
    bit m_gated[CH_NUM];
    bit m_tick [CH_NUM];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < CH_NUM; i++) begin
            m_left[i]  = 1;
            m_cur[i]   = 0;
            m_pend[i]  = 0;
            m_elig[i]  = 0;
            m_pv[i]    = 1'b0;
            m_gated[i] = 1'b0;
            m_tick[i]  = 1'b0;
        end
    endfunction

    function automatic void model_step();
        for (int i = 0; i < CH_NUM; i++) begin
            bit boundary;
            boundary  = 1'b0;
            m_tick[i] = 1'b0;
            if (!m_gated[i]) begin
                m_left[i]--;
                if (m_left[i] == 0) begin
                    boundary  = 1'b1;
                    m_tick[i] = 1'b1;
                    if (m_pv[i]) m_cur[i] = m_pend[i];
                    m_left[i] = 1 << m_cur[i];
                end
            end
            if (div_upd[i]) begin
                m_pend[i] = int'(div_sel[i*DIV_W +: DIV_W]);
                m_pv[i]   = 1'b1;
            end else if (boundary) begin
                m_pv[i]   = 1'b0;
            end
            if (!(sleep_req[i] && !busy[i])) begin
                m_gated[i] = 1'b0;
                m_elig[i]  = 0;
            end else if (!m_gated[i]) begin
                m_elig[i]++;
                if (m_elig[i] >= int'(hold_cycles) + 1) m_gated[i] = 1'b1;
            end
        end
    endfunction

    task automatic check_all();
        logic [CH_NUM-1:0]       e_en, e_tick, e_g;
        logic [CH_NUM*DIV_W-1:0] e_div;
        for (int i = 0; i < CH_NUM; i++) begin
            e_en[i]   = !m_gated[i];
            e_g[i]    = m_gated[i];
            e_tick[i] = m_tick[i];
            e_div[i*DIV_W +: DIV_W] = DIV_W'(m_cur[i]);
        end
        chk("model_clk_en",    32'(clk_en),    32'(e_en));
        chk("model_tick",      32'(tick),      32'(e_tick));
        chk("model_div_cur",   32'(div_cur),   32'(e_div));
        chk("model_gated_sts", 32'(gated_sts), 32'(e_g));
    endtask

    // Inputs are set before the call; outputs are checked on the falling edge.
    task automatic cycle();
        @(posedge sys_clk);
        model_step();
        @(negedge sys_clk);
        check_all();
        div_upd = '0;
    endtask

    task automatic upd(input int ch, input int sel);
        div_sel[ch*DIV_W +: DIV_W] = DIV_W'(sel);
        div_upd[ch] = 1'b1;
    endtask

    task automatic wait_tick(input int ch, input int lim, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!tick[ch] && n < lim);
        chk("tick_timeout", 32'(tick[ch]), 32'd1);
    endtask

    initial begin
        int n;
        sys_rst_n   = 1'b0;
        div_sel     = '0;
        div_upd     = '0;
        sleep_req   = '0;
        busy        = '0;
        hold_cycles = '0;
        model_reset();
        repeat (2) @(negedge sys_clk);
        chk("rst_clk_en",  32'(clk_en),    32'hF);
        chk("rst_tick",    32'(tick),      32'h0);
        chk("rst_div_cur", 32'(div_cur),   32'h0);
        chk("rst_gated",   32'(gated_sts), 32'h0);
        sys_rst_n = 1'b1;

        // Ch0 to divide-by-4.
        upd(0, 2);
        cycle();
        repeat (2) cycle();
        wait_tick(0, 8, n);
        wait_tick(0, 8, n);
        chk("ch0_period", 32'(n), 32'd4);
        chk("ch0_div_cur", 32'(div_cur[0 +: DIV_W]), 32'd2);

        // Ch1 at divide-by-8, then switch to 2 mid-period at cnt=3.
        upd(1, 3);
        cycle();
        wait_tick(1, 20, n);
        wait_tick(1, 20, n);
        chk("ch1_period8", 32'(n), 32'd8);
        repeat (3) cycle();
        upd(1, 1);
        cycle();
        wait_tick(1, 10, n);
        chk("ch1_tail", 32'(n), 32'd4);
        wait_tick(1, 10, n);
        chk("ch1_period2", 32'(n), 32'd2);
        chk("ch1_div_cur", 32'(div_cur[1*DIV_W +: DIV_W]), 32'd1);

        // Ch2 hold-off of 5 cycles.
        hold_cycles  = 4'd5;
        sleep_req[2] = 1'b1;
        cycle();
        repeat (4) cycle();
        chk("ch2_hold_t5", 32'(clk_en[2]), 32'd1);
        cycle();
        chk("ch2_gate_t6", 32'(clk_en[2]), 32'd0);
        chk("ch2_sts_t6", 32'(gated_sts[2]), 32'd1);
        sleep_req[2] = 1'b0;
        cycle();
        chk("ch2_wake", 32'(clk_en[2]), 32'd1);
        repeat (2) cycle();
        sleep_req[2] = 1'b1;
        repeat (3) cycle();
        busy[2] = 1'b1;
        cycle();
        busy[2] = 1'b0;
        repeat (5) cycle();
        chk("ch2_busy_nogate", 32'(clk_en[2]), 32'd1);
        sleep_req[2] = 1'b0;
        cycle();

        // Ch3 at divide-by-4, immediate gating, resume from frozen count.
        upd(3, 2);
        cycle();
        wait_tick(3, 10, n);
        wait_tick(3, 10, n);
        hold_cycles = 4'd0;
        cycle();
        sleep_req[3] = 1'b1;
        cycle();
        chk("ch3_gate_t1", 32'(clk_en[3]), 32'd0);
        repeat (6) cycle();
        sleep_req[3] = 1'b0;
        cycle();
        chk("ch3_wake_t1", 32'(clk_en[3]), 32'd1);
        wait_tick(3, 8, n);
        chk("ch3_resume", 32'(n), 32'd2);

        // Ch0: update on the terminal cycle, then 3 followed by 1.
        wait_tick(0, 8, n);
        repeat (3) cycle();
        upd(0, 3);
        cycle();
        upd(0, 1);
        cycle();
        repeat (2) cycle();
        chk("ch0_before_apply", 32'(div_cur[0 +: DIV_W]), 32'd2);
        cycle();
        chk("ch0_applied", 32'(div_cur[0 +: DIV_W]), 32'd1);
        wait_tick(0, 8, n);
        chk("ch0_new_period", 32'(n), 32'd2);

        // Random traffic.
        for (int k = 0; k < 800; k++) begin
            for (int i = 0; i < CH_NUM; i++) begin
                if ($urandom_range(0, 9) == 0) upd(i, int'($urandom_range(0, 4)));
                if ($urandom_range(0, 15) == 0) sleep_req[i] = ~sleep_req[i];
                busy[i] = ($urandom_range(0, 3) == 0);
            end
            if ($urandom_range(0, 31) == 0) hold_cycles = HOLD_W'($urandom_range(0, 6));
            cycle();
        end

        // Reset while ch3 is gated and others are mid-period.
        busy        = '0;
        sleep_req   = 4'b1000;
        hold_cycles = 4'd0;
        upd(0, 3);
        repeat (3) cycle();
        chk("pre_rst_gated", 32'(gated_sts[3]), 32'd1);
        #2;
        sys_rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_clk_en",  32'(clk_en),    32'hF);
        chk("arst_tick",    32'(tick),      32'h0);
        chk("arst_div_cur", 32'(div_cur),   32'h0);
        chk("arst_gated",   32'(gated_sts), 32'h0);
        @(negedge sys_clk);
        check_all();
        sleep_req = '0;
        sys_rst_n = 1'b1;
        repeat (4) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
